param_accum_core: RTL and testbench



---
 rtl/param_accum_core.sv | 189 ++++++++++++++++++
 tb/tb_param_accum_core.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_accum_core.sv
// param_accum_core: parametrised multi-cycle core with its own program memory,
// register bank, ALU, Z/C flags and a fetch/decode/execute controller.
module param_accum_core #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 4,
  parameter int ADDR_W = 4,
  localparam int INSTR_W = 4 + 2 * REG_AW + DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op,
  input  logic [INSTR_W-1:0] in_data,
  input  logic               user_write_memory,
  input  logic [ADDR_W-1:0]  user_address,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               zero_flag,
  output logic               carry_flag,
  output logic               busy,
  output logic               halted
);

  localparam int unsigned NREGS = 1 << REG_AW;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
    OP_SHL, OP_SHR, OP_JMP, OP_JZ, OP_JC, OP_OUT, OP_RSV, OP_HLT
  } opcode_t;

  state_t state, state_next;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0]  regs [NREGS];
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  op_a, op_b;
  logic               z_flag, c_flag;

  opcode_t            opcode;
  logic [REG_AW-1:0]  rd, rs;
  logic [DATA_W-1:0]  imm;
  logic [ADDR_W-1:0]  target;

  logic [DATA_W-1:0]  alu_res;
  logic [DATA_W:0]    alu_wide;
  logic               alu_c;
  logic               reg_we, flag_we, branch, out_we;

  assign opcode = opcode_t'(ir[INSTR_W-1 -: 4]);
  assign rd     = ir[INSTR_W-5 -: REG_AW];
  assign rs     = ir[INSTR_W-5-REG_AW -: REG_AW];
  assign imm    = ir[DATA_W-1:0];
  assign target = imm[ADDR_W-1:0];

  assign pc_out     = pc;
  assign zero_flag  = z_flag;
  assign carry_flag = c_flag;
  assign busy       = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXECUTE);
  assign halted     = (state == S_HALT);

  // Controller state register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; dropping op returns to IDLE from any state
  always_comb begin
    state_next = state;
    if (!op) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    state_next = S_FETCH;
        S_FETCH:   state_next = S_DECODE;
        S_DECODE:  state_next = S_EXECUTE;
        S_EXECUTE: state_next = (opcode == OP_HLT) ? S_HALT : S_FETCH;
        S_HALT:    state_next = S_HALT;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  // ALU and execute-stage control decoded from ir and the operand latches
  always_comb begin
    alu_res  = '0;
    alu_wide = '0;
    alu_c    = c_flag;
    reg_we   = 1'b0;
    flag_we  = 1'b0;
    branch   = 1'b0;
    out_we   = 1'b0;
    case (opcode)
      OP_LDI: begin alu_res = imm;  reg_we = 1'b1; end
      OP_MOV: begin alu_res = op_b; reg_we = 1'b1; end
      OP_ADD: begin
        alu_wide = {1'b0, op_a} + {1'b0, op_b};
        alu_res  = alu_wide[DATA_W-1:0];
        alu_c    = alu_wide[DATA_W];
        reg_we   = 1'b1;
        flag_we  = 1'b1;
      end
      OP_SUB: begin
        alu_res = op_a - op_b;
        alu_c   = (op_a < op_b);
        reg_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_AND: begin alu_res = op_a & op_b; alu_c = 1'b0; reg_we = 1'b1; flag_we = 1'b1; end
      OP_OR:  begin alu_res = op_a | op_b; alu_c = 1'b0; reg_we = 1'b1; flag_we = 1'b1; end
      OP_XOR: begin alu_res = op_a ^ op_b; alu_c = 1'b0; reg_we = 1'b1; flag_we = 1'b1; end
      OP_SHL: begin
        alu_res = {op_a[DATA_W-2:0], 1'b0};
        alu_c   = op_a[DATA_W-1];
        reg_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_SHR: begin
        alu_res = {1'b0, op_a[DATA_W-1:1]};
        alu_c   = op_a[0];
        reg_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_JMP: branch = 1'b1;
      OP_JZ:  branch = z_flag;
      OP_JC:  branch = c_flag;
      OP_OUT: out_we = 1'b1;
      default: ;
    endcase
  end

  // Program memory user-load port, locked out while running
  always_ff @(posedge clk) begin
    if (!op && user_write_memory) mem[user_address] <= in_data;
  end

  // Datapath: PC, instruction/operand latches, register bank, flags, output
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc        <= '0;
      ir        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      z_flag    <= 1'b0;
      c_flag    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) regs[REG_AW'(i)] <= '0;
    end else begin
      out_valid <= 1'b0;
      if (!op) begin
        pc <= '0;
      end else begin
        case (state)
          S_IDLE:  pc <= '0;
          S_FETCH: begin
            ir <= mem[pc];
            pc <= pc + 1'b1;
          end
          S_DECODE: begin
            op_a <= regs[rd];
            op_b <= regs[rs];
          end
          S_EXECUTE: begin
            if (reg_we) regs[rd] <= alu_res;
            if (flag_we) begin
              z_flag <= (alu_res == '0);
              c_flag <= alu_c;
            end
            // taken branch overrides the increment made during FETCH
            if (branch) pc <= target;
            if (out_we) begin
              out_data  <= op_b;
              out_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_param_accum_core.sv
// Directed self-checking bench for param_accum_core at default parameters.
module tb_param_accum_core;

  localparam int IW = 20;
  localparam int DW = 8;
  localparam int AW = 4;

  localparam logic [3:0] NOP = 4'h0, LDI = 4'h1, MOV = 4'h2, ADD = 4'h3, SUB = 4'h4,
                         AND = 4'h5, OR = 4'h6, XOR = 4'h7, SHL = 4'h8, SHR = 4'h9,
                         JZ = 4'hB, OUT = 4'hD, HLT = 4'hF;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          op = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          user_write_memory = 1'b0;
  logic [AW-1:0] user_address = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [AW-1:0] pc_out;
  logic          zero_flag;
  logic          carry_flag;
  logic          busy;
  logic          halted;

  int checks = 0;
  int fails  = 0;

  param_accum_core dut (
    .clk(clk),
    .reset(reset),
    .op(op),
    .in_data(in_data),
    .user_write_memory(user_write_memory),
    .user_address(user_address),
    .out_data(out_data),
    .out_valid(out_valid),
    .pc_out(pc_out),
    .zero_flag(zero_flag),
    .carry_flag(carry_flag),
    .busy(busy),
    .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] ins(input logic [3:0] o, input logic [3:0] d,
                                         input logic [3:0] s, input logic [7:0] i);
    return {o, d, s, i};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [IW-1:0] w);
    user_address      = a;
    in_data           = w;
    user_write_memory = 1'b1;
    tick();
    user_write_memory = 1'b0;
  endtask

  task automatic wait_out(input int max, output bit found, output int n);
    found = 1'b0;
    n = 0;
    while (!found && n < max) begin
      tick();
      n++;
      if (out_valid === 1'b1) found = 1'b1;
    end
  endtask

  task automatic wait_halt(output int n);
    n = 0;
    while (halted !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    op    = 1'b1;
    tick();
    tick();
    checks++;
    if ({pc_out, out_valid, busy, halted} !== {4'h0, 3'b000}) begin
      fails++;
      $display("FAIL reset_ctrl: pc=%0d valid=%b busy=%b halted=%b, expected 0 0 0 0",
               pc_out, out_valid, busy, halted);
    end
    checks++;
    if ({zero_flag, carry_flag, out_data} !== {2'b00, 8'h00}) begin
      fails++;
      $display("FAIL reset_flags: Z=%b C=%b out=%h, expected 0 0 00", zero_flag, carry_flag, out_data);
    end
    op    = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load_run();
    bit found;
    int n;
    load_word(4'd0, ins(LDI, 4'd1, 4'd0, 8'h05));
    load_word(4'd1, ins(LDI, 4'd2, 4'd0, 8'h03));
    load_word(4'd2, ins(ADD, 4'd1, 4'd2, 8'h00));
    load_word(4'd3, ins(OUT, 4'd0, 4'd1, 8'h00));
    load_word(4'd4, ins(HLT, 4'd0, 4'd0, 8'h00));
    op = 1'b1;
    tick();
    checks++;
    if ({busy, halted, pc_out} !== {2'b10, 4'h0}) begin
      fails++;
      $display("FAIL run_start: busy=%b halted=%b pc=%0d, expected 1 0 0", busy, halted, pc_out);
    end
    wait_out(40, found, n);
    checks++;
    if (!found || n != 12) begin
      fails++;
      $display("FAIL run_out_latency: found=%b cycles=%0d, expected 1 12", found, n);
    end
    checks++;
    if (out_data !== 8'h08) begin
      fails++;
      $display("FAIL run_out_data: got %h, expected 08", out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL run_out_pulse: out_valid=%b one cycle later, expected 0", out_valid);
    end
    tick();
    tick();
    checks++;
    if ({halted, busy, pc_out} !== {2'b10, 4'h5}) begin
      fails++;
      $display("FAIL run_halt: halted=%b busy=%b pc=%0d, expected 1 0 5", halted, busy, pc_out);
    end
    repeat (6) tick();
    checks++;
    if ({halted, out_valid, zero_flag, carry_flag} !== 4'b1000) begin
      fails++;
      $display("FAIL run_halt_hold: halted=%b valid=%b Z=%b C=%b, expected 1 0 0 0",
               halted, out_valid, zero_flag, carry_flag);
    end
    op = 1'b0;
    tick();
    checks++;
    if ({halted, busy, pc_out} !== {2'b00, 4'h0}) begin
      fails++;
      $display("FAIL run_stop: halted=%b busy=%b pc=%0d, expected 0 0 0", halted, busy, pc_out);
    end
  endtask

  task automatic test_carry_zero();
    bit found;
    int n;
    load_word(4'd0,  ins(LDI, 4'd1, 4'd0, 8'hFF));
    load_word(4'd1,  ins(LDI, 4'd2, 4'd0, 8'h01));
    load_word(4'd2,  ins(ADD, 4'd1, 4'd2, 8'h00));
    load_word(4'd3,  ins(JZ,  4'd0, 4'd0, 8'h06));
    load_word(4'd4,  ins(LDI, 4'd3, 4'd0, 8'hAA));
    load_word(4'd5,  ins(OUT, 4'd0, 4'd3, 8'h00));
    load_word(4'd6,  ins(OUT, 4'd0, 4'd1, 8'h00));
    load_word(4'd7,  ins(LDI, 4'd4, 4'd0, 8'h03));
    load_word(4'd8,  ins(LDI, 4'd5, 4'd0, 8'h05));
    load_word(4'd9,  ins(SUB, 4'd4, 4'd5, 8'h00));
    load_word(4'd10, ins(OUT, 4'd0, 4'd4, 8'h00));
    load_word(4'd11, ins(HLT, 4'd0, 4'd0, 8'h00));
    op = 1'b1;
    wait_out(100, found, n);
    checks++;
    if ({found, out_data, zero_flag, carry_flag} !== {1'b1, 8'h00, 2'b11}) begin
      fails++;
      $display("FAIL add_wrap_jz: found=%b out=%h Z=%b C=%b, expected 1 00 1 1",
               found, out_data, zero_flag, carry_flag);
    end
    wait_out(100, found, n);
    checks++;
    if ({found, out_data, zero_flag, carry_flag} !== {1'b1, 8'hFE, 2'b01}) begin
      fails++;
      $display("FAIL sub_borrow: found=%b out=%h Z=%b C=%b, expected 1 fe 0 1",
               found, out_data, zero_flag, carry_flag);
    end
    wait_halt(n);
    checks++;
    if (halted !== 1'b1) begin
      fails++;
      $display("FAIL carry_prog_halt: halted=%b, expected 1", halted);
    end
    op = 1'b0;
    tick();
  endtask

  task automatic test_logic_shift();
    logic [IW-1:0] prog [15];
    logic [DW-1:0] exp_d [5];
    logic [1:0]    exp_zc [5];
    bit found;
    int n;
    prog[0]  = ins(LDI, 4'd1, 4'd0, 8'h81);
    prog[1]  = ins(SHL, 4'd1, 4'd1, 8'h00);
    prog[2]  = ins(OUT, 4'd0, 4'd1, 8'h00);
    prog[3]  = ins(SHR, 4'd1, 4'd1, 8'h00);
    prog[4]  = ins(OUT, 4'd0, 4'd1, 8'h00);
    prog[5]  = ins(LDI, 4'd2, 4'd0, 8'hF0);
    prog[6]  = ins(AND, 4'd2, 4'd1, 8'h00);
    prog[7]  = ins(OUT, 4'd0, 4'd2, 8'h00);
    prog[8]  = ins(LDI, 4'd3, 4'd0, 8'h0F);
    prog[9]  = ins(OR,  4'd3, 4'd1, 8'h00);
    prog[10] = ins(OUT, 4'd0, 4'd3, 8'h00);
    prog[11] = ins(XOR, 4'd3, 4'd3, 8'h00);
    prog[12] = ins(MOV, 4'd5, 4'd1, 8'h00);
    prog[13] = ins(OUT, 4'd0, 4'd5, 8'h00);
    prog[14] = ins(HLT, 4'd0, 4'd0, 8'h00);
    exp_d[0] = 8'h02; exp_zc[0] = 2'b01;
    exp_d[1] = 8'h01; exp_zc[1] = 2'b00;
    exp_d[2] = 8'h00; exp_zc[2] = 2'b10;
    exp_d[3] = 8'h0F; exp_zc[3] = 2'b00;
    exp_d[4] = 8'h01; exp_zc[4] = 2'b10;
    for (int i = 0; i < 15; i++) load_word(AW'(i), prog[i]);
    op = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_out(60, found, n);
      checks++;
      if ({found, out_data, zero_flag, carry_flag} !== {1'b1, exp_d[k], exp_zc[k]}) begin
        fails++;
        $display("FAIL logic_out%0d: found=%b out=%h ZC=%b%b, expected 1 %h %b",
                 k, found, out_data, zero_flag, carry_flag, exp_d[k], exp_zc[k]);
      end
    end
    wait_halt(n);
    op = 1'b0;
    tick();
  endtask

  task automatic test_wrap_loop();
    bit found;
    int n;
    for (int i = 0; i < 15; i++) load_word(AW'(i), ins(NOP, 4'd0, 4'd0, 8'h00));
    load_word(4'd15, ins(OUT, 4'd0, 4'd4, 8'h00));
    op = 1'b1;
    wait_out(80, found, n);
    checks++;
    if ({found, out_data, pc_out} !== {1'b1, 8'hFE, 4'h0} || n != 49) begin
      fails++;
      $display("FAIL wrap_first: found=%b out=%h pc=%0d cycles=%0d, expected 1 fe 0 49",
               found, out_data, pc_out, n);
    end
    for (int lap = 0; lap < 2; lap++) begin
      wait_out(80, found, n);
      checks++;
      if (!found || n != 48) begin
        fails++;
        $display("FAIL wrap_lap%0d: found=%b cycles=%0d, expected 1 48", lap, found, n);
      end
    end
    op = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    bit found;
    int n;
    load_word(4'd0, ins(LDI, 4'd6, 4'd0, 8'h11));
    load_word(4'd1, ins(LDI, 4'd7, 4'd0, 8'h22));
    load_word(4'd2, ins(ADD, 4'd6, 4'd7, 8'h00));
    load_word(4'd3, ins(OUT, 4'd0, 4'd6, 8'h00));
    load_word(4'd4, ins(HLT, 4'd0, 4'd0, 8'h00));
    op = 1'b1;
    repeat (8) tick();
    checks++;
    if ({busy, pc_out} !== {1'b1, 4'h3}) begin
      fails++;
      $display("FAIL abort_pre: busy=%b pc=%0d, expected 1 3", busy, pc_out);
    end
    op = 1'b0;
    tick();
    checks++;
    if ({busy, halted, pc_out, out_valid} !== {2'b00, 4'h0, 1'b0}) begin
      fails++;
      $display("FAIL abort_idle: busy=%b halted=%b pc=%0d valid=%b, expected 0 0 0 0",
               busy, halted, pc_out, out_valid);
    end
    checks++;
    if ({zero_flag, carry_flag} !== 2'b10) begin
      fails++;
      $display("FAIL abort_flags: Z=%b C=%b, expected 1 0", zero_flag, carry_flag);
    end
    load_word(4'd0, ins(OUT, 4'd0, 4'd6, 8'h00));
    load_word(4'd1, ins(HLT, 4'd0, 4'd0, 8'h00));
    op = 1'b1;
    wait_out(20, found, n);
    checks++;
    if ({found, out_data} !== {1'b1, 8'h11} || n != 4) begin
      fails++;
      $display("FAIL abort_rerun: found=%b out=%h cycles=%0d, expected 1 11 4", found, out_data, n);
    end
    wait_halt(n);
    op = 1'b0;
    tick();
  endtask

  task automatic test_write_lockout();
    bit found;
    int n;
    op                = 1'b1;
    user_address      = 4'd0;
    in_data           = ins(OUT, 4'd0, 4'd7, 8'h00);
    user_write_memory = 1'b1;
    tick();
    tick();
    user_write_memory = 1'b0;
    wait_out(20, found, n);
    checks++;
    if ({found, out_data} !== {1'b1, 8'h11}) begin
      fails++;
      $display("FAIL lockout_run: found=%b out=%h, expected 1 11", found, out_data);
    end
    wait_halt(n);
    checks++;
    if (halted !== 1'b1) begin
      fails++;
      $display("FAIL lockout_halt: halted=%b, expected 1", halted);
    end
    op = 1'b0;
    tick();
    op = 1'b1;
    wait_out(20, found, n);
    checks++;
    if ({found, out_data} !== {1'b1, 8'h11}) begin
      fails++;
      $display("FAIL lockout_rerun: found=%b out=%h, expected 1 11", found, out_data);
    end
    wait_halt(n);
    op = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_carry_zero();
    test_logic_shift();
    test_wrap_loop();
    test_abort();
    test_write_lockout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
